// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg
// Shared definitions for the NAND operation sequencer:
//   - instruction mode codes placed in bits [31:28] of each instruction word
//   - host operation codes
//   - NAND command bytes issued by the step lists
//   - byte-source selector used by the step decoder
//   - instruction-word pack helper and op-code legality check
package nand_seq_pkg;

    // Instruction modes understood by the flash control FSM
    localparam logic [3:0] MODE_CMD_IN   = 4'd2;
    localparam logic [3:0] MODE_ADDR_IN  = 4'd3;
    localparam logic [3:0] MODE_DATA_IN  = 4'd4;
    localparam logic [3:0] MODE_DATA_OUT = 4'd5;

    // Host operation codes; 5..7 are illegal
    typedef enum logic [2:0] {
        OP_RESET        = 3'd0,
        OP_READ_STATUS  = 3'd1,
        OP_READ_PAGE    = 3'd2,
        OP_PROGRAM_PAGE = 3'd3,
        OP_ERASE_BLOCK  = 3'd4
    } op_code_e;

    // NAND command bytes
    localparam logic [7:0] NAND_CMD_READ1      = 8'h00;
    localparam logic [7:0] NAND_CMD_READ2      = 8'h30;
    localparam logic [7:0] NAND_CMD_PROG1      = 8'h80;
    localparam logic [7:0] NAND_CMD_PROG2      = 8'h10;
    localparam logic [7:0] NAND_CMD_ERASE1     = 8'h60;
    localparam logic [7:0] NAND_CMD_ERASE2     = 8'hD0;
    localparam logic [7:0] NAND_CMD_STATUS     = 8'h70;
    localparam logic [7:0] NAND_CMD_RESET      = 8'hFF;

    // Where the bytes of a step come from
    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,   // step pushes no bytes (DATA_OUT)
        SRC_CMD   = 3'd1,   // single command byte
        SRC_ADDR5 = 3'd2,   // col[7:0], col[15:8], row[7:0], row[15:8], row[23:16]
        SRC_ADDR3 = 3'd3,   // row[7:0], row[15:8], row[23:16]
        SRC_WDATA = 3'd4    // host payload stream
    } byte_src_e;

    // Build an instruction word; rpt is already zero-extended by the caller
    function automatic logic [31:0] pack_instr(input logic [3:0] mode,
                                               input logic [27:0] rpt);
        return {mode, rpt};
    endfunction

    function automatic logic op_is_legal(input logic [2:0] code);
        return (code <= 3'd4);
    endfunction

endpackage

// File: rtl/nand_step_decode.sv
// nand_step_decode
// Purely combinational step table: maps the latched op code and the current
// step index to the instruction mode, repeat value (count minus 1), byte
// source, command byte and a flag marking the final step of the operation.
// Ports:
//   op_code   in  3     latched operation code
//   step_idx  in  2     current step within the operation
//   op_len    in  LENW  payload bytes minus 1
//   mode      out 4     instruction mode for this step
//   rpt       out LENW  repeat count minus 1
//   cmd_byte  out 8     command byte when src is SRC_CMD
//   src       out       byte source selector
//   last_step out 1     this is the final step of the operation
module nand_step_decode
    import nand_seq_pkg::*;
#(
    parameter int LENW = 13
) (
    input  logic [2:0]      op_code,
    input  logic [1:0]      step_idx,
    input  logic [LENW-1:0] op_len,
    output logic [3:0]      mode,
    output logic [LENW-1:0] rpt,
    output logic [7:0]      cmd_byte,
    output byte_src_e       src,
    output logic            last_step
);

    // Step table lookup; defaults describe a harmless single RESET command
    always_comb begin
        mode      = MODE_CMD_IN;
        rpt       = '0;
        cmd_byte  = NAND_CMD_RESET;
        src       = SRC_CMD;
        last_step = 1'b1;
        case (op_code)
            OP_RESET: begin
                cmd_byte = NAND_CMD_RESET;
            end
            OP_READ_STATUS: begin
                if (step_idx == 2'd0) begin
                    cmd_byte  = NAND_CMD_STATUS;
                    last_step = 1'b0;
                end else begin
                    mode = MODE_DATA_OUT;
                    src  = SRC_NONE;
                end
            end
            OP_READ_PAGE: begin
                last_step = 1'b0;
                case (step_idx)
                    2'd0: cmd_byte = NAND_CMD_READ1;
                    2'd1: begin
                        mode = MODE_ADDR_IN;
                        rpt  = LENW'(4);
                        src  = SRC_ADDR5;
                    end
                    2'd2: cmd_byte = NAND_CMD_READ2;
                    default: begin
                        mode      = MODE_DATA_OUT;
                        rpt       = op_len;
                        src       = SRC_NONE;
                        last_step = 1'b1;
                    end
                endcase
            end
            OP_PROGRAM_PAGE: begin
                last_step = 1'b0;
                case (step_idx)
                    2'd0: cmd_byte = NAND_CMD_PROG1;
                    2'd1: begin
                        mode = MODE_ADDR_IN;
                        rpt  = LENW'(4);
                        src  = SRC_ADDR5;
                    end
                    2'd2: begin
                        mode = MODE_DATA_IN;
                        rpt  = op_len;
                        src  = SRC_WDATA;
                    end
                    default: begin
                        cmd_byte  = NAND_CMD_PROG2;
                        last_step = 1'b1;
                    end
                endcase
            end
            OP_ERASE_BLOCK: begin
                last_step = 1'b0;
                case (step_idx)
                    2'd0: cmd_byte = NAND_CMD_ERASE1;
                    2'd1: begin
                        mode = MODE_ADDR_IN;
                        rpt  = LENW'(2);
                        src  = SRC_ADDR3;
                    end
                    default: begin
                        cmd_byte  = NAND_CMD_ERASE2;
                        last_step = 1'b1;
                    end
                endcase
            end
            default: begin
                last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer
// Turns one high-level NAND operation into a stream of 32-bit instruction
// words (instruction FIFO) and the matching command/address/payload bytes
// (data FIFO) for the downstream flash control FSM.
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   op_valid/op_ready             operation handshake (accepted in IDLE)
//   op_code, op_row, op_col       operation code, row and column address
//   op_len                        payload bytes minus 1
//   wr_data/_valid/_ready         program payload stream
//   iq_wdata, iq_wrreq, iq_full   instruction FIFO write side
//   df_wdata, df_wrreq, df_full   data FIFO write side
//   busy                          operation in progress
//   op_done                       one-cycle pulse after the last push
//   err_bad_op                    one-cycle pulse on an illegal op code
module nand_op_sequencer
    import nand_seq_pkg::*;
#(
    parameter int LENW = 13,
    parameter int RPTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [23:0]     op_row,
    input  logic [15:0]     op_col,
    input  logic [LENW-1:0] op_len,
    input  logic [7:0]      wr_data,
    input  logic            wr_data_valid,
    output logic            wr_data_ready,
    output logic [31:0]     iq_wdata,
    output logic            iq_wrreq,
    input  logic            iq_full,
    output logic [7:0]      df_wdata,
    output logic            df_wrreq,
    input  logic            df_full,
    output logic            busy,
    output logic            op_done,
    output logic            err_bad_op
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MODE  = 3'd1,
        BYTES = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e          state, state_nxt;
    logic [2:0]      op_code_q;
    logic [23:0]     op_row_q;
    logic [15:0]     op_col_q;
    logic [LENW-1:0] op_len_q;
    logic [1:0]      step_idx, step_nxt;
    logic [LENW-1:0] byte_cnt, cnt_nxt;
    logic            accept, bad_op;

    logic [3:0]      step_mode;
    logic [LENW-1:0] step_rpt;
    logic [7:0]      step_cmd;
    byte_src_e       step_src;
    logic            step_last;
    logic [RPTW-1:0] rpt_field;
    logic [31:0]     step_word;
    logic [7:0]      src_byte;

    nand_step_decode #(.LENW(LENW)) u_decode (
        .op_code   (op_code_q),
        .step_idx  (step_idx),
        .op_len    (op_len_q),
        .mode      (step_mode),
        .rpt       (step_rpt),
        .cmd_byte  (step_cmd),
        .src       (step_src),
        .last_step (step_last)
    );

    // Repeat field is zero-extended first to RPTW, then into the 28-bit slot
    assign rpt_field = RPTW'(step_rpt);
    assign step_word = pack_instr(step_mode, 28'(rpt_field));

    // Select the byte for the current step; address bytes are indexed by the
    // byte counter, which never exceeds 4 for address steps
    always_comb begin
        src_byte = step_cmd;
        case (step_src)
            SRC_ADDR5: begin
                case (byte_cnt[2:0])
                    3'd0:    src_byte = op_col_q[7:0];
                    3'd1:    src_byte = op_col_q[15:8];
                    3'd2:    src_byte = op_row_q[7:0];
                    3'd3:    src_byte = op_row_q[15:8];
                    default: src_byte = op_row_q[23:16];
                endcase
            end
            SRC_ADDR3: begin
                case (byte_cnt[1:0])
                    2'd0:    src_byte = op_row_q[7:0];
                    2'd1:    src_byte = op_row_q[15:8];
                    default: src_byte = op_row_q[23:16];
                endcase
            end
            default: src_byte = step_cmd;
        endcase
    end

    // Next-state logic and FIFO strobes; only one FIFO can be written per
    // cycle because MODE writes the instruction FIFO and BYTES the data FIFO
    always_comb begin
        state_nxt     = state;
        step_nxt      = step_idx;
        cnt_nxt       = byte_cnt;
        accept        = 1'b0;
        bad_op        = 1'b0;
        op_ready      = 1'b0;
        op_done       = 1'b0;
        iq_wrreq      = 1'b0;
        iq_wdata      = '0;
        df_wrreq      = 1'b0;
        df_wdata      = '0;
        wr_data_ready = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (op_is_legal(op_code)) begin
                        accept    = 1'b1;
                        state_nxt = MODE;
                        step_nxt  = 2'd0;
                        cnt_nxt   = '0;
                    end else begin
                        bad_op = 1'b1;
                    end
                end
            end
            MODE: begin
                iq_wdata = step_word;
                iq_wrreq = !iq_full;
                if (iq_wrreq) begin
                    cnt_nxt   = '0;
                    state_nxt = (step_mode == MODE_DATA_OUT) ? NEXT : BYTES;
                end
            end
            BYTES: begin
                if (step_src == SRC_WDATA) begin
                    wr_data_ready = wr_data_valid && !df_full;
                    df_wrreq      = wr_data_ready;
                    df_wdata      = wr_data;
                end else begin
                    df_wrreq = !df_full;
                    df_wdata = src_byte;
                end
                if (df_wrreq) begin
                    if (byte_cnt == step_rpt) begin
                        cnt_nxt   = '0;
                        state_nxt = NEXT;
                    end else begin
                        cnt_nxt = byte_cnt + LENW'(1);
                    end
                end
            end
            NEXT: begin
                if (step_last) begin
                    state_nxt = DONE;
                end else begin
                    step_nxt  = step_idx + 2'd1;
                    state_nxt = MODE;
                end
            end
            DONE: begin
                op_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and the latched operation; err_bad_op is registered so
    // it reads 0 throughout reset regardless of op_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            step_idx   <= '0;
            byte_cnt   <= '0;
            op_code_q  <= '0;
            op_row_q   <= '0;
            op_col_q   <= '0;
            op_len_q   <= '0;
            err_bad_op <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_idx   <= step_nxt;
            byte_cnt   <= cnt_nxt;
            err_bad_op <= bad_op;
            if (accept) begin
                op_code_q <= op_code;
                op_row_q  <= op_row;
                op_col_q  <= op_col;
                op_len_q  <= op_len;
            end
        end
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// tb_nand_op_sequencer
// Scoreboard bench for nand_op_sequencer: expected instruction words and
// data bytes are queued when an operation is issued; a negedge monitor pops
// and compares them whenever the sequencer strobes a FIFO write.
module tb_nand_op_sequencer;

    localparam int LENW = 13;
    localparam int RPTW = 16;

    logic            clk;
    logic            rst;
    logic            op_valid;
    logic            op_ready;
    logic [2:0]      op_code;
    logic [23:0]     op_row;
    logic [15:0]     op_col;
    logic [LENW-1:0] op_len;
    logic [7:0]      wr_data;
    logic            wr_data_valid;
    logic            wr_data_ready;
    logic [31:0]     iq_wdata;
    logic            iq_wrreq;
    logic            iq_full;
    logic [7:0]      df_wdata;
    logic            df_wrreq;
    logic            df_full;
    logic            busy;
    logic            op_done;
    logic            err_bad_op;

    nand_op_sequencer #(.LENW(LENW), .RPTW(RPTW)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_code       (op_code),
        .op_row        (op_row),
        .op_col        (op_col),
        .op_len        (op_len),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .iq_wdata      (iq_wdata),
        .iq_wrreq      (iq_wrreq),
        .iq_full       (iq_full),
        .df_wdata      (df_wdata),
        .df_wrreq      (df_wrreq),
        .df_full       (df_full),
        .busy          (busy),
        .op_done       (op_done),
        .err_bad_op    (err_bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] iq_exp[$];
    logic [7:0]  df_exp[$];
    logic [31:0] iq_e;
    logic [7:0]  df_e;
    logic [7:0]  payload [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    int iq_wr_cnt, df_wr_cnt, done_cnt, err_cnt, wdr_cnt, busy_cnt;
    int rule_viol = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearCounters();
        iq_wr_cnt = 0;
        df_wr_cnt = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        wdr_cnt   = 0;
        busy_cnt  = 0;
    endtask

    // Issue one operation; the sequencer must be idle so it is taken at the
    // first rising edge with op_valid high
    task automatic applyStimulus(input logic [2:0] code, input logic [23:0] row,
                                 input logic [15:0] col, input logic [LENW-1:0] len);
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op_code  = code;
        op_row   = row;
        op_col   = col;
        op_len   = len;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic waitDone(input string name, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 500) begin
            @(negedge clk);
            cycles++;
            if (op_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: op_done not seen within %0d cycles", name, cycles);
        end
    endtask

    // Scoreboard monitor: compare every FIFO write against the queued
    // expectations and watch the strobe rules
    always @(negedge clk) begin
        if (rst) begin
            if (iq_wrreq) begin
                iq_wr_cnt++;
                if (iq_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL iq_unexpected: got 0x%0h, expected no write", iq_wdata);
                end else begin
                    iq_e = iq_exp.pop_front();
                    checkOutput("iq_wdata", iq_wdata, iq_e);
                end
            end
            if (df_wrreq) begin
                df_wr_cnt++;
                if (df_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL df_unexpected: got 0x%0h, expected no write", df_wdata);
                end else begin
                    df_e = df_exp.pop_front();
                    checkOutput("df_wdata", 32'(df_wdata), 32'(df_e));
                end
            end
            if ((iq_wrreq && iq_full) || (df_wrreq && df_full) ||
                (wr_data_ready && df_full) || (iq_wrreq && df_wrreq))
                rule_viol++;
            if (op_done)       done_cnt++;
            if (err_bad_op)    err_cnt++;
            if (wr_data_ready) wdr_cnt++;
            if (busy)          busy_cnt++;
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int cyc;
        int n;

        rst           = 1'b0;
        op_valid      = 1'b0;
        op_code       = '0;
        op_row        = '0;
        op_col        = '0;
        op_len        = '0;
        wr_data       = '0;
        wr_data_valid = 1'b0;
        iq_full       = 1'b0;
        df_full       = 1'b0;
        clearCounters();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_op_ready", 32'(op_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_strobes", {29'd0, iq_wrreq, df_wrreq, wr_data_ready}, 32'd0);
        checkOutput("reset_iq_wdata", iq_wdata, 32'd0);
        checkOutput("reset_df_wdata", 32'(df_wdata), 32'd0);
        checkOutput("reset_pulses", {30'd0, op_done, err_bad_op}, 32'd0);
        rst = 1'b1;

        // READ_PAGE, FIFOs never full
        $display("[TB] READ_PAGE");
        clearCounters();
        iq_exp = '{32'h2000_0000, 32'h3000_0004, 32'h2000_0000, 32'h5000_07FF};
        df_exp = '{8'h00, 8'h10, 8'h00, 8'h45, 8'h23, 8'h01, 8'h30};
        applyStimulus(3'd2, 24'h012345, 16'h0010, 13'h7FF);
        waitDone("read_page", cyc);
        @(posedge clk);
        #1;
        checkOutput("read_iq_count", 32'(iq_wr_cnt), 32'd4);
        checkOutput("read_df_count", 32'(df_wr_cnt), 32'd7);
        checkOutput("read_op_done_count", 32'(done_cnt), 32'd1);
        checkOutput("read_queues_drained", 32'(iq_exp.size() + df_exp.size()), 32'd0);
        checkOutput("read_idle_after", 32'(op_ready), 32'd1);

        // PROGRAM_PAGE, len=3, payload valid toggling every other cycle
        $display("[TB] PROGRAM_PAGE");
        clearCounters();
        iq_exp = '{32'h2000_0000, 32'h3000_0004, 32'h4000_0003, 32'h2000_0000};
        df_exp = '{8'h80, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00,
                   8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h10};
        fork
            begin
                applyStimulus(3'd3, 24'h000102, 16'h0304, 13'd3);
                waitDone("program_page", cyc);
            end
            begin
                int idx;
                int k;
                bit took;
                idx = 0;
                k   = 0;
                wr_data = payload[0];
                while (idx < 4 && k < 300) begin
                    @(negedge clk);
                    took = wr_data_valid && wr_data_ready;
                    @(posedge clk);
                    #1;
                    k++;
                    if (took) idx++;
                    if (idx < 4) begin
                        wr_data_valid = ~wr_data_valid;
                        wr_data       = payload[idx];
                    end
                end
                wr_data_valid = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        checkOutput("prog_wr_data_ready_cycles", 32'(wdr_cnt), 32'd4);
        checkOutput("prog_df_count", 32'(df_wr_cnt), 32'd11);
        checkOutput("prog_op_done_count", 32'(done_cnt), 32'd1);
        checkOutput("prog_queues_drained", 32'(iq_exp.size() + df_exp.size()), 32'd0);

        // ERASE_BLOCK with iq_full held high for 10 cycles at the start
        $display("[TB] ERASE_BLOCK");
        clearCounters();
        iq_exp = '{32'h2000_0000, 32'h3000_0002, 32'h2000_0000};
        df_exp = '{8'h60, 8'hEF, 8'hCD, 8'hAB, 8'hD0};
        iq_full = 1'b1;
        applyStimulus(3'd4, 24'hABCDEF, 16'h0000, 13'd0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("erase_no_iq_write_stalled", 32'(iq_wr_cnt), 32'd0);
        checkOutput("erase_busy_stalled", 32'(busy), 32'd1);
        iq_full = 1'b0;
        waitDone("erase_block", cyc);
        @(posedge clk);
        #1;
        checkOutput("erase_iq_count", 32'(iq_wr_cnt), 32'd3);
        checkOutput("erase_df_count", 32'(df_wr_cnt), 32'd5);
        checkOutput("erase_queues_drained", 32'(iq_exp.size() + df_exp.size()), 32'd0);

        // READ_STATUS with df_full high while the command byte is pending
        $display("[TB] READ_STATUS");
        clearCounters();
        iq_exp = '{32'h2000_0000, 32'h5000_0000};
        df_exp = '{8'h70};
        df_full = 1'b1;
        applyStimulus(3'd1, 24'h0, 16'h0, 13'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("status_no_df_write_stalled", 32'(df_wr_cnt), 32'd0);
        checkOutput("status_cmd_word_written", 32'(iq_wr_cnt), 32'd1);
        df_full = 1'b0;
        waitDone("read_status", cyc);
        @(posedge clk);
        #1;
        checkOutput("status_df_count", 32'(df_wr_cnt), 32'd1);
        checkOutput("status_iq_count", 32'(iq_wr_cnt), 32'd2);
        checkOutput("status_queues_drained", 32'(iq_exp.size() + df_exp.size()), 32'd0);

        // Illegal op code
        $display("[TB] illegal op_code");
        clearCounters();
        applyStimulus(3'd6, 24'h123456, 16'h7890, 13'd5);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bad_op_pulses", 32'(err_cnt), 32'd1);
        checkOutput("bad_op_busy_cycles", 32'(busy_cnt), 32'd0);
        checkOutput("bad_op_writes", 32'(iq_wr_cnt + df_wr_cnt), 32'd0);
        checkOutput("bad_op_no_done", 32'(done_cnt), 32'd0);

        // Reset asserted during the address bytes of READ_PAGE
        $display("[TB] reset during READ_PAGE");
        clearCounters();
        iq_exp = '{32'h2000_0000, 32'h3000_0004, 32'h2000_0000, 32'h5000_07FF};
        df_exp = '{8'h00, 8'h10, 8'h00, 8'h45, 8'h23, 8'h01, 8'h30};
        applyStimulus(3'd2, 24'h012345, 16'h0010, 13'h7FF);
        n = 0;
        while (df_wr_cnt < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("rstmid_addr_phase_reached", 32'(df_wr_cnt), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rstmid_strobes", {30'd0, iq_wrreq, df_wrreq}, 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        iq_exp.delete();
        df_exp.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_op_ready_after", 32'(op_ready), 32'd1);
        checkOutput("rstmid_df_count", 32'(df_wr_cnt), 32'd2);

        // RESET op after the interrupted read; 4 negedges from accept to op_done
        clearCounters();
        iq_exp = '{32'h2000_0000};
        df_exp = '{8'hFF};
        applyStimulus(3'd0, 24'h0, 16'h0, 13'd0);
        waitDone("reset_op", cyc);
        checkOutput("reset_op_latency", 32'(cyc), 32'd4);
        @(posedge clk);
        #1;
        checkOutput("reset_op_writes", 32'(iq_wr_cnt + df_wr_cnt), 32'd2);
        checkOutput("reset_op_queues_drained", 32'(iq_exp.size() + df_exp.size()), 32'd0);
        checkOutput("strobe_rules", 32'(rule_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
